// File: rtl/register_writeback.sv
// Register-file write-back: merges ALU results, FIFO-buffered loads and
// inc/dec requests into registered write and inc/dec ports.
module register_writeback #(
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     alu_write,
    input  logic [3:0]               alu_index,
    input  logic [31:0]              alu_data,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [3:0]               load_index,
    input  logic [31:0]              load_data,
    input  logic                     incdec_req,
    input  logic                     incdec_dir,
    input  logic [3:0]               incdec_req_index,
    output logic                     incdec_ack,
    output logic                     rf_write,
    output logic [3:0]               rf_write_index,
    output logic [31:0]              rf_write_data,
    output logic                     rf_inc,
    output logic                     rf_dec,
    output logic [3:0]               rf_incdec_index,
    output logic [15:0]              pending_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

    logic [3:0]    idx_q [DEPTH];
    logic [31:0]   dat_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    logic          wr_q, wr_d;
    logic [3:0]    widx_q, widx_d;
    logic [31:0]   wdat_q, wdat_d;
    logic          inc_q, inc_d;
    logic          dec_q, dec_d;
    logic [3:0]    iidx_q, iidx_d;

    logic          empty, push, pop;
    logic          sel_v;
    logic [3:0]    sel_idx;
    logic [31:0]   sel_dat;
    logic [15:0]   pend;
    logic [AW-1:0] slot;

    assign empty      = (cnt_q == '0);
    // Ready follows the current count only; a same-cycle pop does not help.
    assign load_ready = reset && (cnt_q < CAP);
    assign push       = load_valid && load_ready;
    assign pop        = reset && !alu_write && !empty;

    assign sel_v   = alu_write || !empty;
    assign sel_idx = alu_write ? alu_index : idx_q[rptr_q];
    assign sel_dat = alu_write ? alu_data : dat_q[rptr_q];

    assign incdec_ack = reset && incdec_req &&
                        !(sel_v && (sel_idx == incdec_req_index));

    always_comb begin
        pend = '0;
        slot = rptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rptr_q + AW'(k);
            if ((AW+1)'(k) < cnt_q) pend[idx_q[slot]] = 1'b1;
        end
    end

    always_comb begin
        rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        wr_d   = sel_v;
        widx_d = sel_v ? sel_idx : widx_q;
        wdat_d = sel_v ? sel_dat : wdat_q;
        inc_d  = incdec_ack && !incdec_dir;
        dec_d  = incdec_ack && incdec_dir;
        iidx_d = incdec_ack ? incdec_req_index : iidx_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            wr_q   <= 1'b0;
            widx_q <= '0;
            wdat_q <= '0;
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
            iidx_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            wr_q   <= wr_d;
            widx_q <= widx_d;
            wdat_q <= wdat_d;
            inc_q  <= inc_d;
            dec_q  <= dec_d;
            iidx_q <= iidx_d;
        end
    end

    // Storage needs no reset: validity comes from the pointers and count.
    always_ff @(posedge clock) begin
        if (push) begin
            idx_q[wptr_q] <= load_index;
            dat_q[wptr_q] <= load_data;
        end
    end

    assign rf_write        = wr_q;
    assign rf_write_index  = widx_q;
    assign rf_write_data   = wdat_q;
    assign rf_inc          = inc_q;
    assign rf_dec          = dec_q;
    assign rf_incdec_index = iidx_q;
    assign pending_mask    = pend;
    assign fifo_count      = cnt_q;

endmodule
